ksa32_pg_stage: RTL and testbench
=================================

// Module: ksa32_pg_stage
// PURPOSE
//  Front stage of the 32-bit Kogge-Stone adder pipeline: registers operands A/B and carry-in.
//  Forms bitwise propagate/generate (P=A^B, G=A&B) and presents them as the P_i/G_i vectors
//  consumed by the distance-1 prefix stage.
//  Valid/ready on both sides; a 2-entry skid buffer keeps in_ready free of any
//  combinational path from out_ready.
// PARAMETERS
//  WIDTH  32  operand width; P/G vector width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand word present
//  in_ready   out  1      stage can accept a word this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in
//  out_valid  out  1      P/G word present
//  out_ready  in   1      downstream prefix stage accepts word
//  out_p      out  WIDTH  propagate vector to prefix stage P_i
//  out_g      out  WIDTH  generate vector to prefix stage G_i
//  out_cin    out  1      carry-in travelling with the word (final sum stage)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, out_valid=0, in_ready=1, out_p=0, out_g=0, out_cin=0.
//  - Push = in_valid&in_ready; pop = out_valid&out_ready. Handshake occurs at posedge.
//  - Storage: head register (drives outputs) + skid register; count in {0,1,2}.
//  - in_ready = (count!=2), decoded from registered count only.
//  - out_valid = (count!=0), decoded from registered count only.
//  - States / transitions:
//    EMPTY(0): push -> ONE, head<=new word. No pop possible.
//    ONE(1): push&pop -> ONE, head<=new word.
//            push only -> FULL, skid<=new word.
//            pop only -> EMPTY.
//    FULL(2): pop -> ONE, head<=skid. No push possible (in_ready=0).
//  - Latency: 1 cycle from accepted input to out_valid when EMPTY; throughput 1 word/cycle.
//  - Stall: while out_valid&!out_ready, out_p/out_g/out_cin hold stable, bit for bit.
//  - Ordering: strict FIFO; no word dropped or duplicated.
//  - Arithmetic, per bit i, computed at push time and stored:
//    p[i]=a[i]^b[i]; g[i]=a[i]&b[i]; cin stored alongside.
//  - out_p is always the raw propagate; downstream uses it for the final sum XOR.
//  - Head contents are don't-care when count=0; outputs keep the last value
//    (0 after reset).
//  - Reset mid-operation discards both entries; no partial word emitted afterwards.
//  - in_valid while in_ready=0: ignored, no state change.
// CONFIGURATION
//  KSA_PG_CIN_FOLD_EN defined:
//    g[0] = a[0]&b[0] | (a[0]^b[0])&cin.
//    Carry-in is absorbed into bit 0; downstream prefix carries already include cin.
//    out_cin still carries cin (informational).
//  KSA_PG_CIN_FOLD_EN undefined:
//    g[0] = a[0]&b[0]; downstream adds out_cin itself.
//  Both builds: p[0] = a[0]^b[0].
// TESTING
//  1 Reset: assert rst 2 cycles.
//    -> out_valid=0, in_ready=1, out_p=0, out_g=0 every cycle after.
//  2 Single word, out_ready=1: A=0x0000_00FF, B=0x0000_0F0F, cin=0 at cycle t.
//    -> at t+1 out_valid=1, out_p=0x0000_0FF0, out_g=0x0000_000F.
//  3 Backpressure: out_ready=0, push W0=(0xFFFF_FFFF,0x1), W1=(0xAAAA_AAAA,0x5555_5555).
//    -> in_ready=0 after the 2nd push; out_p stays 0xFFFF_FFFE, out_g stays 0x1.
//    -> after out_ready=1: W0 then W1 (out_p 0xFFFF_FFFF, out_g 0) on consecutive cycles.
//  4 Streaming: 100 random words, in_valid=1, out_ready=1.
//    -> one output per cycle, in order, matching A^B / A&B.
//  5 Cin fold: A=0x1, B=0x0, cin=1.
//    -> with KSA_PG_CIN_FOLD_EN: out_g=0x1.
//    -> without KSA_PG_CIN_FOLD_EN: out_g=0x0, out_cin=1.
//  6 Reset mid-op: FULL state, rst=1 for 1 cycle.
//    -> count=0, out_valid=0, in_ready=1 next cycle; neither stored word appears at output.

Source files
------------

// File: rtl/ksa32_pg_stage.sv
// Kogge-Stone front stage: registers A^B / A&B plus cin behind a 2-entry skid buffer; KSA_PG_CIN_FOLD_EN folds cin into g[0].
// Latency 1 cycle from an accepted word when empty; in_ready/out_valid decode registered state only, so no ready path crosses the stage.
module ksa32_pg_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_cin
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_p_q, head_p_d;
  logic [WIDTH-1:0] head_g_q, head_g_d;
  logic             head_cin_q, head_cin_d;
  logic [WIDTH-1:0] skid_p_q, skid_p_d;
  logic [WIDTH-1:0] skid_g_q, skid_g_d;
  logic             skid_cin_q, skid_cin_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] new_p;
  logic [WIDTH-1:0] new_g;

  always_comb begin
    new_p = in_a ^ in_b;
    new_g = in_a & in_b;
`ifdef KSA_PG_CIN_FOLD_EN
    // Bit 0 generate becomes the true carry out of bit 0, so prefix carries include cin.
    new_g[0] = (in_a[0] & in_b[0]) | (new_p[0] & in_cin);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_p_q   <= '0;
      head_g_q   <= '0;
      head_cin_q <= 1'b0;
      skid_p_q   <= '0;
      skid_g_q   <= '0;
      skid_cin_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_p_q   <= head_p_d;
      head_g_q   <= head_g_d;
      head_cin_q <= head_cin_d;
      skid_p_q   <= skid_p_d;
      skid_g_q   <= skid_g_d;
      skid_cin_q <= skid_cin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_p_d   = head_p_q;
    head_g_d   = head_g_q;
    head_cin_d = head_cin_q;
    skid_p_d   = skid_p_q;
    skid_g_d   = skid_g_q;
    skid_cin_d = skid_cin_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d    = ST_ONE;
          head_p_d   = new_p;
          head_g_d   = new_g;
          head_cin_d = in_cin;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_p_d   = new_p;
          head_g_d   = new_g;
          head_cin_d = in_cin;
        end else if (push) begin
          state_d    = ST_FULL;
          skid_p_d   = new_p;
          skid_g_d   = new_g;
          skid_cin_d = in_cin;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d    = ST_ONE;
          head_p_d   = skid_p_q;
          head_g_d   = skid_g_q;
          head_cin_d = skid_cin_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_p     = head_p_q;
    out_g     = head_g_q;
    out_cin   = head_cin_q;
  end

endmodule

// File: tb/tb_ksa32_pg_stage.sv
// Bench for ksa32_pg_stage: directed cases plus random traffic against a queue scoreboard.
module tb_ksa32_pg_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [31:0] out_g;
  logic        out_cin;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] g;
    logic        cin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  ksa32_pg_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_g(out_g), .out_cin(out_cin)
  );

  always #5 clk = ~clk;

  // Reference: bitwise XOR/AND; with folding, g[0] is the carry out of a 1-bit full add.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    exp_t e;
    e.p   = a ^ b;
    e.g   = a & b;
    e.cin = c;
`ifdef KSA_PG_CIN_FOLD_EN
    e.g[0] = ((32'(a[0]) + 32'(b[0]) + 32'(c)) >= 2);
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acceptance side: record the expected response for every word the DUT takes.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb.push_back(model(in_a, in_b, in_cin));
      n_push++;
    end
  end

  // Output monitor: compare each delivered word, and hold-stability while stalled.
  logic        stalled_prev = 1'b0;
  exp_t        held;
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && out_valid)
        chk("stall_hold", 72'({out_p, out_g, out_cin}), 72'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 72'(1), 72'(0));
        end else begin
          chk("data", 72'({out_p, out_g, out_cin}), 72'(sb.pop_front()));
          n_pop++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = '{p: out_p, g: out_g, cin: out_cin};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_out_valid"}, 72'(out_valid), 72'(0));
    chk({name, "_in_ready"}, 72'(in_ready), 72'(1));
    chk({name, "_pg"}, 72'({out_p, out_g, out_cin}), 72'(0));
  endtask

  initial begin
    logic acc;
    int   budget;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset, then several idle cycles.
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("reset");
      step();
    end

    // Single word with out_ready high: visible one cycle after acceptance.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00FF, 32'h0000_0F0F, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("single_valid", 72'(out_valid), 72'(1));
    chk("single_p", 72'(out_p), 72'(32'h0000_0FF0));
    chk("single_g", 72'(out_g), 72'(32'h0000_000F));
    step();
    @(negedge clk);
    chk("single_drained", 72'(out_valid), 72'(0));

    // Backpressure: two words fill the buffer; head holds W0.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 72'(in_ready), 72'(0));
      chk("bp_head", 72'({out_p, out_g}), 72'({32'hFFFF_FFFE, 32'h0000_0001}));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w0", 72'({out_valid, out_p, out_g}), 72'({1'b1, 32'hFFFF_FFFE, 32'h0000_0001}));
    step();
    @(negedge clk);
    chk("bp_w1", 72'({out_valid, out_p, out_g, out_cin}), 72'({1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1}));
    step();
    @(negedge clk);
    chk("bp_empty", 72'(out_valid), 72'(0));

    // Carry-in folding on bit 0.
    drive(1'b1, 32'h1, 32'h0, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
`ifdef KSA_PG_CIN_FOLD_EN
    chk("fold_g", 72'(out_g), 72'(32'h1));
`else
    chk("fold_g", 72'(out_g), 72'(32'h0));
`endif
    chk("fold_cin", 72'(out_cin), 72'(1));
    step();

    // Streaming: a new word every cycle with no stalls.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(1)));
      step();
      @(negedge clk);
      chk("stream_in_ready", 72'(in_ready), 72'(1));
      chk("stream_out_valid", 72'(out_valid), 72'(1));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step(); step();

    // Random valid/backpressure, holding each word until it is accepted.
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      out_ready = ($urandom_range(3) != 0);
      if (acc || !in_valid) begin
        if ($urandom_range(2) != 0) drive(1'b1, $urandom, $urandom, 1'($urandom_range(1)));
        else drive(1'b0, 32'h0, 32'h0, 1'b0);
      end
    end
    @(negedge clk);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    @(negedge clk);
    chk("drain_empty", 72'(sb.size()), 72'(0));
    chk("push_pop_count", 72'(n_pop), 72'(n_push));

    // Reset while full: both stored words are discarded.
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    step();
    drive(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 72'(in_ready), 72'(0));
    step();
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_idle("midreset");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
